// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared types and constants for the turn controller
package ttt_pkg;

  localparam int CELLS = 9;

  typedef enum logic [1:0] {
    WAIT = 2'd0,
    EVAL = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;

  // Index 0..7: rows, columns, then the two diagonals.
  localparam logic [7:0][CELLS-1:0] WIN_LINES = {
    9'h054,  // 2-4-6
    9'h111,  // 0-4-8
    9'h124,  // 2-5-8
    9'h092,  // 1-4-7
    9'h049,  // 0-3-6
    9'h1c0,  // 6-7-8
    9'h038,  // 3-4-5
    9'h007   // 0-1-2
  };

endpackage

// File: rtl/win_detect.sv
// rtl/win_detect.sv - combinational check of one occupancy mask against all win lines
module win_detect
  import ttt_pkg::*;
(
  input  logic [CELLS-1:0] mask,
  output logic             win
);

  always_comb begin
    win = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if ((mask & WIN_LINES[i]) == WIN_LINES[i]) begin
        win = 1'b1;
      end
    end
  end

endmodule

// File: rtl/turn_controller.sv
// rtl/turn_controller.sv - two-player move arbitration, board tracking and win/draw detection
module turn_controller #(
  parameter int CELLS = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             new_game,
  input  logic             move_valid,
  input  logic [3:0]       move_pos,
  output logic             turn,
  output logic [CELLS-1:0] p1_board,
  output logic [CELLS-1:0] p2_board,
  output logic             move_ack,
  output logic             move_err,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic [3:0]       move_count
);

  import ttt_pkg::*;

  localparam logic [3:0] FULL_COUNT = 4'(CELLS);

  state_t           state, state_n;
  logic             turn_n;
  logic [CELLS-1:0] p1_n, p2_n;
  logic             ack_n, err_n, over_n;
  logic [1:0]       winner_n;
  logic [3:0]       count_n;
  logic [CELLS-1:0] cell_mask;
  logic [CELLS-1:0] mover_board;
  logic             mover_win;

  // Out-of-range positions decode to an empty mask, which makes them illegal.
  assign cell_mask   = (move_pos < FULL_COUNT) ? (CELLS'(1) << move_pos) : '0;
  assign mover_board = turn ? p2_board : p1_board;

  win_detect u_win_detect (
    .mask (mover_board),
    .win  (mover_win)
  );

  always_comb begin
    state_n  = state;
    turn_n   = turn;
    p1_n     = p1_board;
    p2_n     = p2_board;
    ack_n    = 1'b0;
    err_n    = 1'b0;
    over_n   = game_over;
    winner_n = winner;
    count_n  = move_count;
    case (state)
      WAIT: begin
        if (move_valid) begin
          if ((cell_mask != '0) && (((p1_board | p2_board) & cell_mask) == '0)) begin
            if (turn) p2_n = p2_board | cell_mask;
            else      p1_n = p1_board | cell_mask;
            count_n = move_count + 4'd1;
            ack_n   = 1'b1;
            state_n = EVAL;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      EVAL: begin
        // A full board only counts as a draw when the last move did not win.
        if (mover_win) begin
          winner_n = turn ? WIN_P2 : WIN_P1;
          over_n   = 1'b1;
          state_n  = OVER;
        end else if (move_count == FULL_COUNT) begin
          winner_n = WIN_NONE;
          over_n   = 1'b1;
          state_n  = OVER;
        end else begin
          turn_n  = ~turn;
          state_n = WAIT;
        end
      end
      OVER: begin
        state_n = OVER;
      end
      default: begin
        state_n = WAIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      state      <= WAIT;
      turn       <= 1'b0;
      p1_board   <= '0;
      p2_board   <= '0;
      move_ack   <= 1'b0;
      move_err   <= 1'b0;
      game_over  <= 1'b0;
      winner     <= WIN_NONE;
      move_count <= 4'd0;
    end else begin
      state      <= state_n;
      turn       <= turn_n;
      p1_board   <= p1_n;
      p2_board   <= p2_n;
      move_ack   <= ack_n;
      move_err   <= err_n;
      game_over  <= over_n;
      winner     <= winner_n;
      move_count <= count_n;
    end
  end

endmodule

// File: tb/tb_turn_controller.sv
// tb/tb_turn_controller.sv - self-checking bench for turn_controller
module tb_turn_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       new_game = 1'b0;
  logic       move_valid = 1'b0;
  logic [3:0] move_pos = 4'd0;
  logic       turn;
  logic [8:0] p1_board, p2_board;
  logic       move_ack, move_err, game_over;
  logic [1:0] winner;
  logic [3:0] move_count;

  turn_controller #(.CELLS(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .new_game   (new_game),
    .move_valid (move_valid),
    .move_pos   (move_pos),
    .turn       (turn),
    .p1_board   (p1_board),
    .p2_board   (p2_board),
    .move_ack   (move_ack),
    .move_err   (move_err),
    .game_over  (game_over),
    .winner     (winner),
    .move_count (move_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: cell owner 0 = empty, 1 = P1, 2 = P2.
  int m_b[9];
  int m_turn, m_count, m_over, m_winner;
  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  logic       s_ack, s_err, s_over;
  logic [8:0] s_p1, s_p2;

  function automatic logic [8:0] m_mask(input int who);
    logic [8:0] m = '0;
    for (int i = 0; i < 9; i++) if (m_b[i] == who) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 9; i++) m_b[i] = 0;
    m_turn = 0; m_count = 0; m_over = 0; m_winner = 0;
  endtask

  task automatic model_move(input int pos, output bit e_ack, output bit e_err);
    int mover;
    bit won;
    e_ack = 0; e_err = 0;
    if (m_over != 0) return;
    if (pos > 8) begin e_err = 1; return; end
    if (m_b[pos] != 0) begin e_err = 1; return; end
    e_ack = 1;
    mover = m_turn + 1;
    m_b[pos] = mover;
    m_count++;
    won = 0;
    for (int l = 0; l < 8; l++)
      if (m_b[lines[l][0]] == mover && m_b[lines[l][1]] == mover && m_b[lines[l][2]] == mover) won = 1;
    if (won) begin m_over = 1; m_winner = mover; end
    else if (m_count == 9) begin m_over = 1; m_winner = 0; end
    else m_turn ^= 1;
  endtask

  // Request in cycle N; N+1 outputs captured into s_*; returns sampling cycle N+2.
  task automatic apply_move(input int pos);
    @(negedge clk);
    move_valid = 1'b1;
    move_pos = 4'(pos);
    @(negedge clk);
    s_ack = move_ack; s_err = move_err; s_over = game_over;
    s_p1 = p1_board; s_p2 = p2_board;
    move_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_all(input bit r, input bit ng);
    @(negedge clk);
    reset = r; new_game = ng;
    @(negedge clk);
    reset = 1'b0; new_game = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    clear_all(1'b1, 1'b0);
    checks++; if ({turn, p1_board, p2_board, move_ack, move_err, game_over, winner, move_count} !== 28'd0) begin
      errors++; $display("FAIL reset_vals got %h exp 0", {turn, p1_board, p2_board, move_ack, move_err, game_over, winner, move_count});
    end
  endtask

  task automatic test_p1_row_win();
    clear_all(1'b0, 1'b1);
    apply_move(0); apply_move(3); apply_move(1); apply_move(4); apply_move(2);
    checks++; if (s_ack !== 1'b1) begin errors++; $display("FAIL row_ack got %b exp 1", s_ack); end
    checks++; if (s_p1 !== 9'h007) begin errors++; $display("FAIL row_p1 got %h exp 007", s_p1); end
    checks++; if (s_over !== 1'b0) begin errors++; $display("FAIL row_over_early got %b exp 0", s_over); end
    checks++; if (winner !== 2'b01) begin errors++; $display("FAIL row_winner got %b exp 01", winner); end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL row_over got %b exp 1", game_over); end
    checks++; if (move_count !== 4'd5) begin errors++; $display("FAIL row_count got %0d exp 5", move_count); end
    checks++; if (turn !== 1'b0) begin errors++; $display("FAIL row_turn got %b exp 0", turn); end
  endtask

  task automatic test_illegal();
    clear_all(1'b0, 1'b1);
    apply_move(4);
    apply_move(4);
    checks++; if (s_err !== 1'b1 || s_ack !== 1'b0) begin errors++; $display("FAIL occ_err got ack %b err %b exp ack 0 err 1", s_ack, s_err); end
    checks++; if (s_p2 !== 9'h000) begin errors++; $display("FAIL occ_p2 got %h exp 000", s_p2); end
    checks++; if (turn !== 1'b1) begin errors++; $display("FAIL occ_turn got %b exp 1", turn); end
    apply_move(9);
    checks++; if (s_err !== 1'b1 || s_ack !== 1'b0) begin errors++; $display("FAIL range_err got ack %b err %b exp ack 0 err 1", s_ack, s_err); end
    checks++; if ({p1_board, p2_board, move_count, turn} !== {9'h010, 9'h000, 4'd1, 1'b1}) begin
      errors++; $display("FAIL range_state got %h exp %h", {p1_board, p2_board, move_count, turn}, {9'h010, 9'h000, 4'd1, 1'b1});
    end
  endtask

  task automatic test_draw();
    int seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    clear_all(1'b0, 1'b1);
    foreach (seq[i]) apply_move(seq[i]);
    checks++; if ({winner, game_over, move_count} !== {2'b00, 1'b1, 4'd9}) begin
      errors++; $display("FAIL draw_end got w %b o %b c %0d exp w 00 o 1 c 9", winner, game_over, move_count);
    end
    checks++; if ({p1_board, p2_board} !== {9'h18d, 9'h072}) begin
      errors++; $display("FAIL draw_boards got %h %h exp 18d 072", p1_board, p2_board);
    end
    apply_move(5);
    checks++; if (s_ack !== 1'b0 || s_err !== 1'b0) begin errors++; $display("FAIL draw_ignore got ack %b err %b exp 0 0", s_ack, s_err); end
  endtask

  task automatic test_back_to_back();
    clear_all(1'b0, 1'b1);
    @(negedge clk);
    move_valid = 1'b1; move_pos = 4'd0;
    @(negedge clk);
    checks++; if (move_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %b exp 1", move_ack); end
    move_pos = 4'd1;
    @(negedge clk);
    move_valid = 1'b0;
    checks++; if (move_ack !== 1'b0 || move_err !== 1'b0) begin errors++; $display("FAIL b2b_drop got ack %b err %b exp 0 0", move_ack, move_err); end
    @(negedge clk);
    checks++; if ({p1_board, p2_board, turn, move_count} !== {9'h001, 9'h000, 1'b1, 4'd1}) begin
      errors++; $display("FAIL b2b_state got %h exp %h", {p1_board, p2_board, turn, move_count}, {9'h001, 9'h000, 1'b1, 4'd1});
    end
  endtask

  task automatic test_new_game_with_move();
    clear_all(1'b0, 1'b1);
    apply_move(0); apply_move(3);
    @(negedge clk);
    new_game = 1'b1; move_valid = 1'b1; move_pos = 4'd5;
    @(negedge clk);
    new_game = 1'b0; move_valid = 1'b0;
    checks++; if ({turn, p1_board, p2_board, move_ack, move_err, game_over, winner, move_count} !== 28'd0) begin
      errors++; $display("FAIL ng_move got %h exp 0", {turn, p1_board, p2_board, move_ack, move_err, game_over, winner, move_count});
    end
    // Both clears together, then a clear landing in the evaluation cycle.
    apply_move(2);
    @(negedge clk);
    reset = 1'b1; new_game = 1'b1;
    @(negedge clk);
    reset = 1'b0; new_game = 1'b0;
    checks++; if ({p1_board, move_count, turn} !== 14'd0) begin errors++; $display("FAIL both_clear got %h exp 0", {p1_board, move_count, turn}); end
    @(negedge clk);
    move_valid = 1'b1; move_pos = 4'd6;
    @(negedge clk);
    move_valid = 1'b0; new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    checks++; if ({p1_board, move_count, turn, game_over} !== 15'd0) begin errors++; $display("FAIL eval_clear got %h exp 0", {p1_board, move_count, turn, game_over}); end
    model_clear();
    apply_move(7);
    checks++; if (s_ack !== 1'b1 || s_p1 !== 9'h080) begin errors++; $display("FAIL eval_clear_wait got ack %b p1 %h exp 1 080", s_ack, s_p1); end
  endtask

  task automatic test_p2_diag_win();
    int seq[6] = '{1, 0, 2, 4, 3, 8};
    clear_all(1'b0, 1'b1);
    foreach (seq[i]) apply_move(seq[i]);
    checks++; if ({winner, game_over, turn} !== {2'b10, 1'b1, 1'b1}) begin
      errors++; $display("FAIL diag_end got w %b o %b t %b exp 10 1 1", winner, game_over, turn);
    end
    apply_move(5);
    repeat (3) @(negedge clk);
    checks++; if ({s_ack, s_err, turn, winner, p1_board, p2_board} !== {1'b0, 1'b0, 1'b1, 2'b10, 9'h00e, 9'h111}) begin
      errors++; $display("FAIL diag_hold got %h exp %h", {s_ack, s_err, turn, winner, p1_board, p2_board}, {1'b0, 1'b0, 1'b1, 2'b10, 9'h00e, 9'h111});
    end
  endtask

  task automatic test_random_games();
    bit ea, ee;
    int pos;
    for (int g = 0; g < 25; g++) begin
      clear_all(g[0], !g[0]);
      for (int k = 0; k < 40 && m_over == 0; k++) begin
        pos = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 8);
        model_move(pos, ea, ee);
        apply_move(pos);
        checks++; if (s_ack !== ea || s_err !== ee) begin errors++; $display("FAIL rnd_pulse g%0d pos %0d got ack %b err %b exp %b %b", g, pos, s_ack, s_err, ea, ee); end
        checks++; if (s_p1 !== m_mask(1) || s_p2 !== m_mask(2)) begin errors++; $display("FAIL rnd_board g%0d got %h %h exp %h %h", g, s_p1, s_p2, m_mask(1), m_mask(2)); end
        checks++; if (turn !== m_turn[0] || move_count !== 4'(m_count)) begin errors++; $display("FAIL rnd_turn g%0d got t %b c %0d exp t %0d c %0d", g, turn, move_count, m_turn, m_count); end
        checks++; if (game_over !== m_over[0] || winner !== m_winner[1:0]) begin errors++; $display("FAIL rnd_end g%0d got o %b w %b exp o %0d w %0d", g, game_over, winner, m_over, m_winner); end
      end
      if (m_over != 0) begin
        pos = $urandom_range(0, 15);
        apply_move(pos);
        checks++; if (s_ack !== 1'b0 || s_err !== 1'b0 || move_count !== 4'(m_count)) begin
          errors++; $display("FAIL rnd_over_ignore g%0d got ack %b err %b c %0d exp 0 0 %0d", g, s_ack, s_err, move_count, m_count);
        end
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_p1_row_win();
    test_illegal();
    test_draw();
    test_back_to_back();
    test_new_game_with_move();
    test_p2_diag_win();
    test_random_games();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
